// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CSR UART TX write port and the transmitter, drained by a 3-state FSM.
// Define UART_TX_FIFO_FLUSH_EN to enable the flush input; otherwise flush is ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovrflw,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    tx_wdata,
  output logic          tx_wr,
  input  logic          tx_tbr_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    tx_wdata_q;
  logic          tx_wr_q;
  state_e        state_q;
  logic          flush_act, pop, push_ok, drop;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted.
  assign pop     = (state_q == ISSUE) && !flush_act;
  assign push_ok = wr_en && !flush_act && (!full || pop);
  assign drop    = wr_en && !flush_act && full && !pop;

  always_comb begin
    level_d = level_q;
    if (flush_act)
      level_d = '0;
    else if (push_ok && !pop)
      level_d = level_q + 1'b1;
    else if (pop && !push_ok)
      level_d = level_q - 1'b1;

    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (clr_ovrflw)
      overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wp_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (flush_act) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push_ok)
          wp_q <= wp_q + 1'b1;
        if (pop)
          rp_q <= rp_q + 1'b1;
      end
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // HOLDOFF ignores tx_tbr_valid for one cycle because the transmitter's status lags the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_wdata_q <= 8'h00;
      tx_wr_q    <= 1'b0;
    end else if (flush_act) begin
      state_q <= IDLE;
      tx_wr_q <= 1'b0;
    end else begin
      tx_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty && tx_tbr_valid)
            state_q <= ISSUE;
        end
        ISSUE: begin
          tx_wdata_q <= mem_q[rp_q];
          tx_wr_q    <= 1'b1;
          state_q    <= HOLDOFF;
        end
        HOLDOFF: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_wdata = tx_wdata_q;
  assign tx_wr    = tx_wr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: queue-based reference model checked every cycle plus directed literals.
// Honours UART_TX_FIFO_FLUSH_EN the same way the design does.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_TX_FIFO_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovrflw = 1'b0;
  logic          flush = 1'b0;
  logic          tx_tbr_valid = 1'b0;
  logic          full, empty, overflow, tx_wr;
  logic [AW:0]   level;
  logic [7:0]    tx_wdata;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_ovrflw   (clr_ovrflw),
    .flush        (flush),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .tx_wdata     (tx_wdata),
    .tx_wr        (tx_wr),
    .tx_tbr_valid (tx_tbr_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic v,
                               input logic c, input logic f);
    wr_en        = w;
    wr_data      = d;
    tx_tbr_valid = v;
    clr_ovrflw   = c;
    flush        = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte queue, plus "issue pending" and "cool-down" flags for drain pacing.
  logic [7:0] mq[$];
  bit         mIssue, mHold, mOvf, mTxWr;
  logic [7:0] mTxData;
  bit         mPop, mAccept, mDrop, mWasEmpty, mFlush, mNext;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mIssue  = 1'b0;
      mHold   = 1'b0;
      mOvf    = 1'b0;
      mTxWr   = 1'b0;
      mTxData = 8'h00;
    end else begin
      mFlush    = FLUSH_ON && flush;
      mWasEmpty = (mq.size() == 0);
      if (mFlush) begin
        mq.delete();
        mIssue = 1'b0;
        mHold  = 1'b0;
        mTxWr  = 1'b0;
        if (clr_ovrflw) mOvf = 1'b0;
      end else begin
        mPop    = mIssue;
        mAccept = wr_en && (mq.size() < DEPTH || mPop);
        mDrop   = wr_en && !mAccept;
        if (mPop) mTxData = mq.pop_front();
        if (mAccept) mq.push_back(wr_data);
        mTxWr  = mPop;
        mNext  = !mIssue && !mHold && !mWasEmpty && tx_tbr_valid;
        mHold  = mPop;
        mIssue = mNext;
        if (mDrop) mOvf = 1'b1;
        else if (clr_ovrflw) mOvf = 1'b0;
      end
    end
  end

  bit         checkEn = 1'b0;
  logic [7:0] txLog[$];
  int         txCyc[$];
  int         lastTx = -100;

  always @(negedge clk) begin
    if (!rst && checkEn) begin
      checkOutput("level", level, mq.size());
      checkOutput("full", full, mq.size() == DEPTH);
      checkOutput("empty", empty, mq.size() == 0);
      checkOutput("overflow", overflow, mOvf);
      checkOutput("tx_wr", tx_wr, mTxWr);
      checkOutput("tx_wdata", tx_wdata, mTxData);
      if (tx_wr === 1'b1) begin
        checkOutput("pop_spacing", (cyc - lastTx) >= 3, 1);
        txLog.push_back(tx_wdata);
        txCyc.push_back(cyc);
        lastTx = cyc;
      end
    end
  end

  int pushCyc;
  int base;

  initial begin
    applyStimulus(0, 8'h00, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_txwdata", tx_wdata, 8'h00);
    repeat (10) tick();

    // Single byte latency: visible on the 3rd edge after the push cycle.
    applyStimulus(1, 8'h41, 1, 0, 0);
    pushCyc = cyc;
    tick();
    applyStimulus(0, 8'h00, 1, 0, 0);
    repeat (6) tick();
    checkOutput("lat_count", txLog.size(), 1);
    if (txLog.size() >= 1) begin
      checkOutput("lat_data", txLog[0], 8'h41);
      checkOutput("lat_cycles", txCyc[0] - pushCyc, 3);
    end
    checkOutput("lat_level", level, 0);

    // Fill, overflow, clear/set priority, then drain.
    applyStimulus(0, 8'h00, 0, 0, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, i[7:0], 0, 0, 0);
      tick();
    end
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_level", level, 16);
    applyStimulus(1, 8'h55, 0, 0, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_level", level, 16);
    applyStimulus(0, 8'h00, 0, 1, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("ovf_clr", overflow, 0);
    applyStimulus(1, 8'h66, 0, 1, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("ovf_set_wins", overflow, 1);
    applyStimulus(0, 8'h00, 0, 1, 0);
    tick();
    base = txLog.size();
    applyStimulus(0, 8'h00, 1, 0, 0);
    repeat (60) tick();
    checkOutput("drain_count", txLog.size() - base, 16);
    for (int i = 0; i < 16; i++)
      if (base + i < txLog.size())
        checkOutput("drain_order", txLog[base + i], i);

    // Full FIFO, push accepted in the ISSUE cycle; pointers wrap.
    applyStimulus(0, 8'h00, 0, 0, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'h10 + i[7:0], 0, 0, 0);
      tick();
    end
    base = txLog.size();
    applyStimulus(0, 8'h00, 1, 0, 0);
    tick();
    applyStimulus(1, 8'hAA, 1, 0, 0);
    tick();
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("wrap_level", level, 16);
    checkOutput("wrap_no_ovf", overflow, 0);
    repeat (70) tick();
    checkOutput("wrap_count", txLog.size() - base, 17);
    for (int i = 0; i < 16; i++)
      if (base + i < txLog.size())
        checkOutput("wrap_order", txLog[base + i], 8'h10 + i);
    if (base + 16 < txLog.size())
      checkOutput("wrap_last", txLog[base + 16], 8'hAA);

    // Flush together with a push.
    applyStimulus(0, 8'h00, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'h30 + i[7:0], 0, 0, 0);
      tick();
    end
    applyStimulus(1, 8'h35, 0, 0, 1);
    tick();
    applyStimulus(0, 8'h00, 0, 0, 0);
    base = txLog.size();
    checkOutput("flush_level", level, FLUSH_ON ? 0 : 6);
    checkOutput("flush_ovf", overflow, 0);
    applyStimulus(0, 8'h00, 1, 0, 0);
    repeat (40) tick();
    checkOutput("flush_count", txLog.size() - base, FLUSH_ON ? 0 : 6);
    if (!FLUSH_ON)
      for (int i = 0; i < 6; i++)
        if (base + i < txLog.size())
          checkOutput("noflush_order", txLog[base + i], 8'h30 + i);

    // Asynchronous reset in the middle of a tx_wr pulse.
    applyStimulus(1, 8'h77, 1, 0, 0);
    tick();
    applyStimulus(0, 8'h00, 1, 0, 0);
    tick();
    tick();
    checkOutput("pre_rst_txwr", tx_wr, 1);
    checkOutput("pre_rst_txwdata", tx_wdata, 8'h77);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_txwr", tx_wr, 0);
    checkOutput("async_rst_txwdata", tx_wdata, 8'h00);
    checkOutput("async_rst_level", level, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    lastTx = -100;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
